// File: rtl/aes_dmem_loader.sv
// Packs 32-bit host words into VLEN-bit lines and writes them to data memory.
// Define LOADER_BYTESWAP_EN to byte-reverse each word before packing.
module aes_dmem_loader #(
  parameter int VLEN  = 128,
  parameter int WORDS = VLEN / 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic [31:0]     base_addr,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            mem_we,
  output logic            mem_vector,
  output logic [31:0]     mem_addr,
  output logic [VLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic [15:0]     line_count
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [31:0] STRIDE = 32'(VLEN / 8);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [VLEN-1:0] buffer;
  logic [VLEN-1:0] buf_nxt;
  logic [31:0]     addr;
  logic [31:0]     word;
  logic            last_q;
  logic            accept;

`ifdef LOADER_BYTESWAP_EN
  assign word = {in_data[7:0], in_data[15:8],
                 in_data[23:16], in_data[31:24]};
`else
  assign word = in_data;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    buf_nxt = buffer;
    buf_nxt[{idx, 5'd0} +: 32] = word;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      idx        <= '0;
      buffer     <= '0;
      addr       <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_vector <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      line_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            addr       <= {base_addr[31:4], 4'b0};
            idx        <= '0;
            buffer     <= '0;
            line_count <= '0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            // the completing word goes straight into the write line
            if (in_last || idx == LAST_IDX) begin
              state      <= WRITE;
              in_ready   <= 1'b0;
              mem_we     <= 1'b1;
              mem_vector <= 1'b1;
              mem_wdata  <= buf_nxt;
              mem_addr   <= addr;
              last_q     <= in_last;
            end else begin
              buffer <= buf_nxt;
              idx    <= idx + IW'(1);
            end
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          mem_vector <= 1'b0;
          addr       <= addr + STRIDE;
          if (line_count != 16'hFFFF)
            line_count <= line_count + 16'd1;
          if (last_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FILL;
            in_ready <= 1'b1;
            buffer   <= '0;
            idx      <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dmem_loader.sv
// Self-checking bench for aes_dmem_loader.
// Randomized sessions are checked against a line-level reference model.
module tb_aes_dmem_loader;

  localparam int VLEN  = 128;
  localparam int WORDS = VLEN / 32;

  logic            clk = 1'b0;
  logic            clrn;
  logic            start;
  logic [31:0]     base_addr;
  logic            in_valid;
  logic [31:0]     in_data;
  logic            in_last;
  logic            in_ready;
  logic            mem_we;
  logic            mem_vector;
  logic [31:0]     mem_addr;
  logic [VLEN-1:0] mem_wdata;
  logic            busy;
  logic            done;
  logic [15:0]     line_count;

  aes_dmem_loader #(.VLEN(VLEN)) dut (
    .clk(clk), .clrn(clrn), .start(start),
    .base_addr(base_addr), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we),
    .mem_vector(mem_vector), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .line_count(line_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vec_err = 0;

  logic [31:0]     wa_q[$];
  logic [VLEN-1:0] wd_q[$];
  int              wc_q[$];
  int              dc_q[$];
  logic [31:0]     words_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_vector !== mem_we) vec_err <= vec_err + 1;
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) dc_q.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [VLEN-1:0] obs,
                       input logic [VLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xform(input logic [31:0] w);
`ifdef LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dc_q.delete();
  endtask

  task automatic run_session(input logic [31:0] base,
                             input int gap_pct,
                             input bit pair_valid);
    int n, nl, i, budget;
    logic rdy;
    logic [31:0] a;
    logic [VLEN-1:0] d;
    n = words_q.size();
    nl = (n + WORDS - 1) / WORDS;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    in_valid = pair_valid;
    in_data = 32'hDEADBEEF;
    in_last = pair_valid;
    check("idle_ready", VLEN'(in_ready), VLEN'(0));
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    check("busy_after_start", VLEN'(busy), VLEN'(1));
    i = 0;
    budget = 0;
    while (i < n && budget < 2000) begin
      budget++;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        start = 1'($urandom_range(1));
        base_addr = $urandom;
      end else begin
        start = 1'b0;
        in_valid = 1'b1;
        in_data = words_q[i];
        in_last = (i == n - 1);
      end
      rdy = in_ready;
      @(negedge clk);
      if (in_valid && rdy) i++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    check("accepted_words", VLEN'(i), VLEN'(n));
    budget = 0;
    while (dc_q.size() == 0 && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("write_count", VLEN'(wa_q.size()), VLEN'(nl));
    for (int l = 0; l < nl && l < wa_q.size(); l++) begin
      a = (base & 32'hFFFF_FFF0) + 32'(l * (VLEN / 8));
      d = '0;
      for (int k = 0; k < WORDS; k++)
        if (l * WORDS + k < n)
          d[32*k +: 32] = xform(words_q[l * WORDS + k]);
      check($sformatf("addr_l%0d", l), VLEN'(wa_q[l]), VLEN'(a));
      check($sformatf("data_l%0d", l), wd_q[l], d);
    end
    check("done_pulses", VLEN'(dc_q.size()), VLEN'(1));
    if (dc_q.size() > 0 && wc_q.size() > 0)
      check("done_timing", VLEN'(dc_q[0]),
            VLEN'(wc_q[wc_q.size() - 1] + 1));
    check("line_count", VLEN'(line_count), VLEN'(nl));
    check("busy_end", VLEN'(busy), VLEN'(0));
    check("vector_eq_we", VLEN'(vec_err), VLEN'(0));
  endtask

  initial begin
    logic [VLEN-1:0] zero_outs;
    int n;
    clrn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    zero_outs = VLEN'({in_ready, mem_we, mem_vector, busy, done});
    check("rst_flags", zero_outs, '0);
    check("rst_addr", VLEN'(mem_addr), '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_lcount", VLEN'(line_count), '0);
    clrn = 1'b1;
    @(negedge clk);

    // single full line, unaligned base
    words_q = '{32'h00112233, 32'h44556677,
                32'h8899AABB, 32'hCCDDEEFF};
    run_session(32'h105, 0, 1'b0);
`ifndef LOADER_BYTESWAP_EN
    if (wd_q.size() > 0)
      check("vec_wdata", wd_q[0],
            128'hCCDDEEFF_8899AABB_44556677_00112233);
`endif

    words_q = '{};
    for (int k = 0; k < 8; k++) words_q.push_back($urandom);
    run_session(32'h200, 0, 1'b0);

    words_q = '{32'hA, 32'hB};
    run_session(32'h300, 0, 1'b1);

    words_q = '{};
    for (int k = 0; k < 8; k++) words_q.push_back($urandom);
    run_session(32'hFFFF_FFF0, 30, 1'b0);

    // abort after three accepted words
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    base_addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 32'h5A5A_0000 + k;
      @(negedge clk);
    end
    in_valid = 1'b0;
    clrn = 1'b0;
    #1;
    zero_outs = VLEN'({in_ready, mem_we, mem_vector, busy, done});
    check("abort_flags", zero_outs, '0);
    check("abort_addr", VLEN'(mem_addr), '0);
    check("abort_wdata", mem_wdata, '0);
    check("abort_lcount", VLEN'(line_count), '0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", VLEN'(wa_q.size()), '0);

    words_q = '{32'h11223344};
    run_session(32'h500, 0, 1'b0);
`ifdef LOADER_BYTESWAP_EN
    if (wd_q.size() > 0)
      check("byteswap", wd_q[0], VLEN'(32'h44332211));
`endif

    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 11);
      words_q = '{};
      for (int k = 0; k < n; k++) words_q.push_back($urandom);
      run_session($urandom, 40, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_dmem_loader.md
AES_DMEM_LOADER -- requirements
Module: aes_dmem_loader

Interface
REQ-001 Parameter VLEN, default 128, width of one vector memory line in bits; legal values are multiples of 32.
REQ-002 Parameter WORDS, default VLEN/32, number of 32-bit words packed per line.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clrn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session at base_addr.
REQ-006 base_addr  input  32  byte address of the first line; low 4 bits are treated as zero.
REQ-007 in_valid  input  1  host word valid.
REQ-008 in_data  input  32  host word (plaintext/key/round-key data).
REQ-009 in_last  input  1  marks the final word of the session; qualified by in_valid.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 mem_we  output  1  one-cycle vector write strobe to data memory.
REQ-012 mem_vector  output  1  vector-access flag to data memory; equals mem_we.
REQ-013 mem_addr  output  32  byte address of the line being written.
REQ-014 mem_wdata  output  VLEN  packed line; word 0 in bits [31:0].
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle pulse after the last line write.
REQ-017 line_count  output  16  lines written in the current or last session.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, FILL, WRITE and DONE.
REQ-019 IDLE->FILL on start: latch {base_addr[31:4],4'b0} into the address register, clear the word index, clear the packing buffer and clear line_count.
REQ-020 A word SHALL be accepted only when in_valid && in_ready; in_ready SHALL be 1 only in FILL.
REQ-021 Accepted word i SHALL be stored in bits [32i+31:32i] of the buffer, and the index SHALL increment.
REQ-022 FILL->WRITE on acceptance of word WORDS-1, or on acceptance of any word with in_last=1.
REQ-023 On in_last with a partial line, unfilled words SHALL remain zero.
REQ-024 In WRITE, mem_we=mem_vector=1 for exactly one cycle with the buffered mem_wdata and mem_addr; the first write SHALL occur on the cycle after the completing word is accepted.
REQ-025 After each write, line_count SHALL increment by 1 and the address SHALL increase by VLEN/8, wrapping modulo 2^32.
REQ-026 WRITE->FILL (buffer and index cleared) if the last accepted word did not carry in_last; otherwise WRITE->DONE.
REQ-027 DONE SHALL pulse done for one cycle, then go to IDLE; busy SHALL be 1 in FILL, WRITE and DONE.
REQ-028 start while busy SHALL be ignored.
REQ-029 start and in_valid asserted in the same cycle from IDLE: the word SHALL NOT be accepted (in_ready=0 in IDLE).
REQ-030 line_count SHALL saturate at 16'hFFFF.
REQ-031 Outside WRITE, mem_we=mem_vector=0; mem_addr and mem_wdata SHALL hold their registered values.

Reset
REQ-032 On clrn=0, asynchronously: state=IDLE; in_ready, mem_we, mem_vector, busy and done=0; mem_addr=0; mem_wdata=0; line_count=0.
REQ-033 Reset asserted mid-session SHALL abort the session with no write issued; partially packed data SHALL be discarded.

Configuration
REQ-034 Macro LOADER_BYTESWAP_EN: when defined, each accepted in_data SHALL be byte-reversed ({b0,b1,b2,b3}) before packing; when undefined, words SHALL be stored unmodified.

Verification
REQ-035 start with base_addr=0x105, then 4 words 0x00112233..0xCCDDEEFF with the last word carrying in_last -> one write at 0x100 with wdata=0xCCDDEEFF_8899AABB_44556677_00112233, then done, line_count=1.
REQ-036 8 words with in_last on word 8 and base_addr=0x200 -> writes at 0x200 and 0x210, done one cycle after the second write, line_count=2.
REQ-037 2 words (0xA, 0xB) with in_last on the second word -> single write of wdata=0x0..0_0000000B_0000000A.
REQ-038 base_addr=0xFFFFFFF0, 8 words -> writes at 0xFFFFFFF0 and then 0x00000000.
REQ-039 clrn pulsed low after 3 words are accepted -> no mem_we; all outputs are zero; the next session behaves normally.
REQ-040 LOADER_BYTESWAP_EN defined, single word 0x11223344 with in_last -> wdata[31:0]=0x44332211, with upper bits zero.
